wb_stage: RTL and testbench

//  Write-back stage of the 5-stage pipeline: the producing end of the register-file write port consumed by decode.

---
 rtl/pipe_pkg.sv | 27 ++
 rtl/load_align.sv | 29 ++
 rtl/wb_stage.sv | 85 ++++++++
 tb/tb_wb_stage.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline constants: datapath widths, write-back control bit indices and load-size encodings.
package pipe_pkg;

   localparam int DATA_W = 32;
   localparam int REG_AW = 5;

   localparam int WB_CTRL_REGWRITE = 1;
   localparam int WB_CTRL_MEMTOREG = 0;

   typedef enum logic [1:0] {
      LD_WORD = 2'b00,
      LD_HALF = 2'b01,
      LD_BYTE = 2'b10,
      LD_RSVD = 2'b11
   } ld_size_e;

   typedef struct packed {
      logic              valid;
      logic [1:0]        ctrl;
      logic [DATA_W-1:0] alu_result;
      logic [DATA_W-1:0] mem_data;
      logic [REG_AW-1:0] write_reg;
      ld_size_e          ld_size;
      logic              ld_unsigned;
   } mem_wb_t;

endpackage

// File: rtl/load_align.sv
// Little-endian load alignment and extension; reserved size behaves as a full-word load.
module load_align
   import pipe_pkg::*;
(
   input  logic [DATA_W-1:0] raw_word,
   input  logic [1:0]        offset,
   input  ld_size_e          size,
   input  logic              is_unsigned,
   output logic [DATA_W-1:0] data_out
);

   logic [15:0]       half_sel;
   logic [7:0]        byte_sel;
   logic [DATA_W-1:0] shifted;

   // NOTE: every signal assigned here gets a default first so no path can infer a latch.
   always_comb begin
      shifted  = raw_word >> {offset, 3'b000};
      half_sel = offset[1] ? raw_word[31:16] : raw_word[15:0];
      byte_sel = shifted[7:0];
      data_out = raw_word;
      case (size)
         LD_HALF: data_out = {{16{~is_unsigned & half_sel[15]}}, half_sel};
         LD_BYTE: data_out = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
         default: data_out = raw_word;
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB register with stall/flush, load alignment and write-port drive.
// Optional retire counter enabled by defining WB_RETIRE_COUNT_EN.
module wb_stage
   import pipe_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              flush,
   input  logic              valid_in,
   input  logic [1:0]        wb_ctrl_in,
   input  logic [DATA_W-1:0] alu_result_in,
   input  logic [DATA_W-1:0] mem_read_data,
   input  logic [REG_AW-1:0] write_reg_in,
   input  logic [1:0]        ld_size_in,
   input  logic              ld_unsigned_in,
   output logic              reg_write,
   output logic [REG_AW-1:0] mem_wb_writereg,
   output logic [DATA_W-1:0] mem_wb_writedata,
   output logic              wb_valid
`ifdef WB_RETIRE_COUNT_EN
   ,
   output logic [31:0]       retire_count
`endif
);

   mem_wb_t           mem_wb_q, mem_wb_d;
   logic [DATA_W-1:0] aligned_load;

   // Flush outranks stall; reset is applied in the register itself.
   always_comb begin
      mem_wb_d = mem_wb_q;
      if (flush) begin
         mem_wb_d = '0;
      end else if (!stall) begin
         mem_wb_d.valid       = valid_in;
         mem_wb_d.ctrl        = wb_ctrl_in;
         mem_wb_d.alu_result  = alu_result_in;
         mem_wb_d.mem_data    = mem_read_data;
         mem_wb_d.write_reg   = write_reg_in;
         mem_wb_d.ld_size     = ld_size_e'(ld_size_in);
         mem_wb_d.ld_unsigned = ld_unsigned_in;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk) begin
      if (reset) mem_wb_q <= '0;
      else       mem_wb_q <= mem_wb_d;
   end

   load_align u_load_align (
      .raw_word    (mem_wb_q.mem_data),
      .offset      (mem_wb_q.alu_result[1:0]),
      .size        (mem_wb_q.ld_size),
      .is_unsigned (mem_wb_q.ld_unsigned),
      .data_out    (aligned_load)
   );

   always_comb begin
      wb_valid         = mem_wb_q.valid;
      mem_wb_writereg  = mem_wb_q.write_reg;
      reg_write        = mem_wb_q.valid & mem_wb_q.ctrl[WB_CTRL_REGWRITE]
                         & (mem_wb_q.write_reg != '0);
      mem_wb_writedata = mem_wb_q.ctrl[WB_CTRL_MEMTOREG] ? aligned_load : mem_wb_q.alu_result;
   end

`ifdef WB_RETIRE_COUNT_EN
   logic [31:0] retire_q, retire_d;

   // Only edges that actually load a real instruction count; wraps naturally.
   always_comb begin
      retire_d = retire_q;
      if (!flush && !stall && valid_in) retire_d = retire_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) retire_q <= '0;
      else       retire_q <= retire_d;
   end

   assign retire_count = retire_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage; define WB_RETIRE_COUNT_EN to also exercise the retire counter.
module tb_wb_stage;

   logic        clk = 1'b0;
   logic        reset, stall, flush, valid_in, ld_unsigned_in;
   logic [1:0]  wb_ctrl_in, ld_size_in;
   logic [31:0] alu_result_in, mem_read_data;
   logic [4:0]  write_reg_in;
   logic        reg_write, wb_valid;
   logic [4:0]  mem_wb_writereg;
   logic [31:0] mem_wb_writedata;
`ifdef WB_RETIRE_COUNT_EN
   logic [31:0] retire_count;
`endif

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   wb_stage dut (
      .clk              (clk),
      .reset            (reset),
      .stall            (stall),
      .flush            (flush),
      .valid_in         (valid_in),
      .wb_ctrl_in       (wb_ctrl_in),
      .alu_result_in    (alu_result_in),
      .mem_read_data    (mem_read_data),
      .write_reg_in     (write_reg_in),
      .ld_size_in       (ld_size_in),
      .ld_unsigned_in   (ld_unsigned_in),
      .reg_write        (reg_write),
      .mem_wb_writereg  (mem_wb_writereg),
      .mem_wb_writedata (mem_wb_writedata),
      .wb_valid         (wb_valid)
`ifdef WB_RETIRE_COUNT_EN
      ,
      .retire_count     (retire_count)
`endif
   );

   // Observed bundle: {reg_write, wb_valid, writereg, writedata}
   function automatic logic [38:0] obs();
      return {reg_write, wb_valid, mem_wb_writereg, mem_wb_writedata};
   endfunction

   task automatic drive(input logic v, input logic [1:0] ctrl, input logic [31:0] alu,
                        input logic [31:0] mem, input logic [4:0] wreg,
                        input logic [1:0] size, input logic uns);
      valid_in       = v;
      wb_ctrl_in     = ctrl;
      alu_result_in  = alu;
      mem_read_data  = mem;
      write_reg_in   = wreg;
      ld_size_in     = size;
      ld_unsigned_in = uns;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [38:0] got;
      reset = 1'b1; stall = 1'b0; flush = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 2'($urandom), $urandom, $urandom, 5'($urandom), 2'($urandom), 1'($urandom));
         stall = 1'($urandom);
         flush = 1'($urandom);
         step();
         got = obs();
         tests_run++;
         if (got !== 39'h0) begin
            tests_failed++;
            $display("FAIL reset_cycle%0d: got %h expected %h", i, got, 39'h0);
         end
      end
      reset = 1'b0; stall = 1'b0; flush = 1'b0;
      drive(1'b1, 2'b10, 32'h0000_1234, 32'h5555_AAAA, 5'd5, 2'b00, 1'b0);
      step();
      got = obs();
      tests_run++;
      if (got !== {1'b1, 1'b1, 5'd5, 32'h0000_1234}) begin
         tests_failed++;
         $display("FAIL first_load: got %h expected %h", got, {1'b1, 1'b1, 5'd5, 32'h0000_1234});
      end
   endtask

   task automatic test_load_align();
      // {size, offset, unsigned, expected}
      logic [36:0] vec [7];
      vec[0] = {2'b10, 2'd3, 1'b0, 32'hFFFF_FF80};
      vec[1] = {2'b10, 2'd3, 1'b1, 32'h0000_0080};
      vec[2] = {2'b01, 2'd2, 1'b0, 32'hFFFF_80FF};
      vec[3] = {2'b01, 2'd0, 1'b0, 32'h0000_7F01};
      vec[4] = {2'b10, 2'd1, 1'b0, 32'h0000_007F};
      vec[5] = {2'b00, 2'd1, 1'b0, 32'h80FF_7F01};
      vec[6] = {2'b11, 2'd2, 1'b1, 32'h80FF_7F01};
      for (int i = 0; i < 7; i++) begin
         drive(1'b1, 2'b11, {28'h1000_000, 2'b00, vec[i][34:33]}, 32'h80FF_7F01, 5'd7,
               vec[i][36:35], vec[i][32]);
         step();
         tests_run++;
         if (mem_wb_writedata !== vec[i][31:0] || reg_write !== 1'b1) begin
            tests_failed++;
            $display("FAIL align_vec%0d: got data %h we %b expected data %h we 1",
                     i, mem_wb_writedata, reg_write, vec[i][31:0]);
         end
      end
   endtask

   task automatic test_r0_and_bubble();
      drive(1'b1, 2'b10, 32'hDEAD_BEEF, 32'h0, 5'd0, 2'b00, 1'b0);
      step();
      tests_run++;
      if (obs() !== {1'b0, 1'b1, 5'd0, 32'hDEAD_BEEF}) begin
         tests_failed++;
         $display("FAIL r0_suppress: got %h expected %h", obs(), {1'b0, 1'b1, 5'd0, 32'hDEAD_BEEF});
      end
      drive(1'b0, 2'b10, 32'h0000_0042, 32'h0, 5'd9, 2'b00, 1'b0);
      step();
      tests_run++;
      if (obs() !== {1'b0, 1'b0, 5'd9, 32'h0000_0042}) begin
         tests_failed++;
         $display("FAIL invalid_no_write: got %h expected %h", obs(), {1'b0, 1'b0, 5'd9, 32'h0000_0042});
      end
   endtask

   task automatic test_stall();
      drive(1'b1, 2'b10, 32'h11, 32'h0, 5'd3, 2'b00, 1'b0);
      step();
      stall = 1'b1;
      drive(1'b1, 2'b10, 32'h22, 32'h0, 5'd4, 2'b00, 1'b0);
      for (int i = 0; i < 2; i++) begin
         step();
         tests_run++;
         if (obs() !== {1'b1, 1'b1, 5'd3, 32'h11}) begin
            tests_failed++;
            $display("FAIL stall_hold%0d: got %h expected %h", i, obs(), {1'b1, 1'b1, 5'd3, 32'h11});
         end
      end
      stall = 1'b0;
      step();
      tests_run++;
      if (obs() !== {1'b1, 1'b1, 5'd4, 32'h22}) begin
         tests_failed++;
         $display("FAIL stall_release: got %h expected %h", obs(), {1'b1, 1'b1, 5'd4, 32'h22});
      end
   endtask

   task automatic test_flush();
      stall = 1'b1; flush = 1'b1;
      drive(1'b1, 2'b11, 32'h33, 32'hFFFF_FFFF, 5'd6, 2'b00, 1'b0);
      step();
      tests_run++;
      if (obs() !== 39'h0) begin
         tests_failed++;
         $display("FAIL flush_over_stall: got %h expected %h", obs(), 39'h0);
      end
      stall = 1'b0; flush = 1'b0;
      drive(1'b1, 2'b10, 32'h44, 32'h0, 5'd8, 2'b00, 1'b0);
      step();
      tests_run++;
      if (obs() !== {1'b1, 1'b1, 5'd8, 32'h44}) begin
         tests_failed++;
         $display("FAIL after_flush: got %h expected %h", obs(), {1'b1, 1'b1, 5'd8, 32'h44});
      end
   endtask

`ifdef WB_RETIRE_COUNT_EN
   task automatic test_retire_count();
      reset = 1'b1; stall = 1'b0; flush = 1'b0;
      step();
      tests_run++;
      if (retire_count !== 32'd0) begin
         tests_failed++;
         $display("FAIL retire_reset: got %h expected %h", retire_count, 32'd0);
      end
      reset = 1'b0;
      drive(1'b1, 2'b10, 32'h1, 32'h0, 5'd1, 2'b00, 1'b0);
      for (int i = 0; i < 5; i++) step();
      stall = 1'b1;
      step(); step();
      stall = 1'b0; flush = 1'b1;
      step();
      flush = 1'b0; valid_in = 1'b0;
      step();
      tests_run++;
      if (retire_count !== 32'd5) begin
         tests_failed++;
         $display("FAIL retire_mix: got %h expected %h", retire_count, 32'd5);
      end
      force dut.retire_q = 32'hFFFF_FFFF;
      #1;
      release dut.retire_q;
      valid_in = 1'b1;
      step();
      tests_run++;
      if (retire_count !== 32'd0) begin
         tests_failed++;
         $display("FAIL retire_wrap: got %h expected %h", retire_count, 32'd0);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_load_align();
      test_r0_and_bubble();
      test_stall();
      test_flush();
`ifdef WB_RETIRE_COUNT_EN
      test_retire_count();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
